// File: rtl/passcode_checker.sv
// passcode_checker: assembles keypad digits into a passcode, drives a timed unlock,
// counts consecutive failures into a timed lockout and re-programs the code while open.
module passcode_checker #(
    parameter int                  PW_LEN         = 4,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW     = 16'h1234,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCK_CYCLES    = 1000,
    parameter int                  OPEN_CYCLES    = 500,
    parameter int                  TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_v,
    input  logic [3:0] index,
    input  logic       set_req,
    output logic       unlock,
    output logic       fail,
    output logic       locked,
    output logic       set_done,
    output logic [3:0] digit_cnt
);
    localparam int BW   = PW_LEN * 4;
    localparam int TMAX = (TIMEOUT_CYCLES > OPEN_CYCLES)
                        ? ((TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES)
                        : ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_SET, S_LOCK} state_t;

    state_t        r_state, w_state;
    logic [BW-1:0] r_buf, w_buf, r_code, w_code, w_next;
    logic [3:0]    r_cnt, w_cnt;
    logic [FW-1:0] r_fcnt, w_fcnt;
    logic [TW-1:0] r_timer, w_timer;
    logic          r_unlock, w_unlock, r_fail, w_fail, r_locked, w_locked, r_set_done, w_set_done;
    logic          w_valid, w_last, w_tmo, w_open_end, w_lock_end;

    assign w_valid    = input_v && (index <= 4'd9);
    assign w_next     = BW'({r_buf, index});
    assign w_last     = (r_cnt == 4'(PW_LEN - 1));
    assign w_tmo      = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_open_end = (r_timer == TW'(OPEN_CYCLES - 1));
    assign w_lock_end = (r_timer == TW'(LOCK_CYCLES - 1));

    always_comb begin
        w_state    = r_state;
        w_buf      = r_buf;
        w_code     = r_code;
        w_cnt      = r_cnt;
        w_fcnt     = r_fcnt;
        w_timer    = (r_timer == TW'(TMAX)) ? r_timer : r_timer + 1'b1;
        w_unlock   = r_unlock;
        w_fail     = 1'b0;
        w_locked   = r_locked;
        w_set_done = 1'b0;
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (w_valid) begin
                    w_timer = '0;
                    if (w_last) begin
                        w_buf = '0;
                        w_cnt = '0;
                        if (w_next == r_code) begin
                            w_state  = S_OPEN;
                            w_unlock = 1'b1;
                            w_fcnt   = '0;
                        end else begin
                            w_fail = 1'b1;
                            // fail_cnt parks at MAX_FAIL for the whole lockout
                            if (r_fcnt >= FW'(MAX_FAIL - 1)) begin
                                w_state  = S_LOCK;
                                w_locked = 1'b1;
                                w_fcnt   = FW'(MAX_FAIL);
                            end else begin
                                w_state = S_IDLE;
                                w_fcnt  = r_fcnt + 1'b1;
                            end
                        end
                    end else begin
                        w_state = S_ENTRY;
                        w_buf   = w_next;
                        w_cnt   = r_cnt + 4'd1;
                    end
                end else if (r_state == S_ENTRY && w_tmo) begin
                    w_state = S_IDLE;
                    w_buf   = '0;
                    w_cnt   = '0;
                end
            end
            S_OPEN: begin
                if (set_req) begin
                    w_state = S_SET;
                    w_timer = '0;
                end else if (w_open_end) begin
                    w_state  = S_IDLE;
                    w_unlock = 1'b0;
                end
            end
            S_SET: begin
                if (w_valid) begin
                    w_timer = '0;
                    if (w_last) begin
                        w_state    = S_IDLE;
                        w_code     = w_next;
                        w_buf      = '0;
                        w_cnt      = '0;
                        w_unlock   = 1'b0;
                        w_set_done = 1'b1;
                    end else begin
                        w_buf = w_next;
                        w_cnt = r_cnt + 4'd1;
                    end
                end else if (w_tmo) begin
                    w_state  = S_IDLE;
                    w_buf    = '0;
                    w_cnt    = '0;
                    w_unlock = 1'b0;
                end
            end
            S_LOCK: begin
                if (w_lock_end) begin
                    w_state  = S_IDLE;
                    w_locked = 1'b0;
                    w_fcnt   = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_code     <= DEFAULT_PW;
            r_cnt      <= '0;
            r_fcnt     <= '0;
            r_timer    <= '0;
            r_unlock   <= 1'b0;
            r_fail     <= 1'b0;
            r_locked   <= 1'b0;
            r_set_done <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_buf      <= w_buf;
            r_code     <= w_code;
            r_cnt      <= w_cnt;
            r_fcnt     <= w_fcnt;
            r_timer    <= w_timer;
            r_unlock   <= w_unlock;
            r_fail     <= w_fail;
            r_locked   <= w_locked;
            r_set_done <= w_set_done;
        end
    end

    assign unlock    = r_unlock;
    assign fail      = r_fail;
    assign locked    = r_locked;
    assign set_done  = r_set_done;
    assign digit_cnt = r_cnt;
endmodule
